stream_demux_n: RTL and testbench
=================================

Name: stream_demux_n

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry holding buffer, so back-pressure on one channel does not stall beats routed to other channels.
- Supports a unicast mode (route by select) and a broadcast mode (copy to all channels).
- Detects and counts out-of-range selects.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- N_CH, 4, number of output channels, minimum 2.
- DATA_W, 1, width of one data beat.
- SEL_W, derived as ceil(log2(N_CH)), select width; local constant, not overridable.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = unicast, 1 = broadcast; sampled only on an accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DATA_W  input beat
- in_sel  in  SEL_W  destination channel in unicast mode; ignored in broadcast mode
- out_valid  out  N_CH  per-channel buffer holds a beat
- out_ready  in  N_CH  per-channel consumer ready
- out_data  out  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- err_sel  out  1  one-cycle pulse: an out-of-range select was dropped
- drop_cnt  out  CNT_W  saturating count of dropped beats

Behaviour:
- Reset:
  - Asynchronous assertion; deassertion is synchronous to clk.
  - Reset values: out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
  - Reset mid-transfer discards all buffered beats.
- Channel slot i has two states: EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
  - Slot i is free this cycle when it is EMPTY, or when it is FULL and out_ready[i]=1.
  - Pop: FULL && out_ready[i] takes the slot to EMPTY, unless it is refilled in the same cycle (FULL -> FULL with the new data).
- Invariant: out_data of a channel is 0 whenever its out_valid is 0. On a pop with no refill, that channel's out_data clears to 0.
- in_ready (combinational from out_ready and slot state; no dependence on in_valid):
  - Unicast, in_sel < N_CH: in_ready = free[in_sel].
  - Unicast, in_sel >= N_CH (possible only when N_CH is not a power of 2): in_ready=1.
  - Broadcast: in_ready = AND of free[i] over all i.
- Accept (in_valid && in_ready), registered at the next clock edge, so latency from input to output is 1 cycle:
  - Unicast, valid select: slot[in_sel] loads in_data and becomes FULL. All other slots are unaffected.
  - Broadcast: every slot loads in_data and becomes FULL.
  - Unicast, invalid select: no slot is written. err_sel=1 for exactly the next cycle, and drop_cnt increments, holding at 2^CNT_W-1.
- err_sel is 0 in every cycle without a fresh invalid accept. Back-to-back invalid accepts give err_sel held high, one increment per accepted beat.
- Full-rate operation: with out_ready held high, one beat per cycle is sustained per channel and in aggregate.
- Beat order is preserved per channel. There is no ordering relation between channels.
- Mode may change on any cycle; it affects only beats accepted in that cycle. Beats already buffered are unaffected.
- in_data and in_sel are don't-care when in_valid=0. No state changes without an accept or a pop.

Decomposition:
- Shared package contents: mode encoding constants (MODE_UNICAST=0, MODE_BROADCAST=1) and the select-width computation function.
- One sub-module, demux_slot: a one-entry buffer with load/pop, data clear on empty, and a free output. It is instantiated N_CH times in a generate loop.
- The top level holds the routing, in_ready logic, err_sel and drop_cnt.

Test Plan:
1. Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0. Assert rst_n low asynchronously while slots are FULL -> out_valid=0 immediately, with no clock edge.
2. Unicast, N_CH=4, DATA_W=8, all out_ready=1: send 0x11, 0x22, 0x33, 0x44 with sel 0..3 on consecutive cycles -> each appears on its channel one cycle later, in_ready always 1, other channels show valid=0 and data=0.
3. Back-pressure: out_ready[2]=0; send 0xA5 to ch2, then 0x5A to ch2, then 0x77 to ch1 -> ch2 holds 0xA5 and in_ready=0 for the second ch2 beat; once that beat is withdrawn, the ch1 beat is accepted; raise out_ready[2] -> 0xA5 pops, 0x5A is accepted on the same edge and appears next cycle.
4. Broadcast: mode=1, send 0xC3 with ch3 FULL and stalled -> in_ready=0; release ch3 -> all four channels show 0xC3 in the same cycle.
5. Invalid select: N_CH=3, sel=3 for 5 consecutive beats -> in_ready=1, no out_valid change, err_sel high for 5 cycles, drop_cnt=5.
6. Saturation: CNT_W=2, 6 invalid beats -> drop_cnt stops at 3; err_sel still pulses once per accepted beat.

Source files
------------

// File: rtl/stream_demux_n_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package stream_demux_n_pkg;

  localparam logic MODE_UNICAST   = 1'b0;
  localparam logic MODE_BROADCAST = 1'b1;

  // Width needed to address n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: loads a beat, pops on ready, and keeps its data at zero while empty.
module demux_slot #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // A load is only issued while the slot is free, so it also covers the pop-and-refill case.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with unicast/broadcast routing and an invalid-select drop counter.
module stream_demux_n
  import stream_demux_n_pkg::*;
#(
  parameter int  N_CH   = 4,
  parameter int  DATA_W = 1,
  parameter int  CNT_W  = 8,
  localparam int SEL_W  = sel_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic [N_CH-1:0]  sel_hit;
  logic [N_CH-1:0]  free;
  logic [N_CH-1:0]  load;
  logic             sel_ok;
  logic             accept;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // sel_ok is low only for selects beyond the last channel (non-power-of-two N_CH).
  assign sel_ok = |sel_hit;
  assign accept = in_valid && in_ready;

  always_comb begin
    if (mode == MODE_BROADCAST) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = |(free & sel_hit);
    end else begin
      in_ready = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign sel_hit[gi] = (in_sel == SEL_W'(gi));
      assign load[gi]    = accept && ((mode == MODE_BROADCAST) || sel_hit[gi]);

      demux_slot #(.DATA_W(DATA_W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[gi]),
        .load_data (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[gi*DATA_W +: DATA_W]),
        .free      (free[gi])
      );
    end
  endgenerate

  always_comb begin
    err_d = accept && (mode == MODE_UNICAST) && !sel_ok;
    cnt_d = cnt_q;
    if (err_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench: stimulus queues expected beats per channel, a monitor pops them on output handshakes.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Four-channel, byte-wide instance
  logic        mode4 = 1'b0, v4 = 1'b0, rdy4;
  logic [7:0]  data4 = '0;
  logic [1:0]  sel4 = '0;
  logic [3:0]  ov4, or4 = '0;
  logic [31:0] od4;
  logic        err4;
  logic [7:0]  cnt4;

  // Two three-channel instances sharing stimulus, differing in counter width
  logic        mode3 = 1'b0, v3 = 1'b0, rdy3a, rdy3b;
  logic [7:0]  data3 = '0;
  logic [1:0]  sel3 = '0;
  logic [2:0]  or3 = 3'b111, ov3a, ov3b;
  logic [23:0] od3a, od3b;
  logic        err3a, err3b;
  logic [7:0]  cnt3a;
  logic [1:0]  cnt3b;

  stream_demux_n #(.N_CH(4), .DATA_W(8), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .in_valid(v4), .in_ready(rdy4),
    .in_data(data4), .in_sel(sel4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .err_sel(err4), .drop_cnt(cnt4));

  stream_demux_n #(.N_CH(3), .DATA_W(8), .CNT_W(8)) dut3a (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .in_valid(v3), .in_ready(rdy3a),
    .in_data(data3), .in_sel(sel3), .out_valid(ov3a), .out_ready(or3),
    .out_data(od3a), .err_sel(err3a), .drop_cnt(cnt3a));

  stream_demux_n #(.N_CH(3), .DATA_W(8), .CNT_W(2)) dut3b (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .in_valid(v3), .in_ready(rdy3b),
    .in_data(data3), .in_sel(sel3), .out_valid(ov3b), .out_ready(or3),
    .out_data(od3b), .err_sel(err3b), .drop_cnt(cnt3b));

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] q8_t[$];
  q8_t exp_q[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // Monitor: every output handshake must deliver the oldest expected beat of that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ov4[i] && or4[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL ch%0d_pop: got 0x%0h with no beat expected", i, od4[i*8 +: 8]);
          end else begin
            logic [7:0] e;
            e = exp_q[i].pop_front();
            if (od4[i*8 +: 8] !== e) begin
              errors++;
              $display("FAIL ch%0d_pop: got 0x%0h expected 0x%0h", i, od4[i*8 +: 8], e);
            end else begin
              $display("ok   ch%0d_pop: 0x%0h", i, e);
            end
          end
        end else if (!ov4[i] && od4[i*8 +: 8] !== 8'h00) begin
          checks++;
          errors++;
          $display("FAIL ch%0d_idle_data: got 0x%0h expected 0x0", i, od4[i*8 +: 8]);
        end
      end
    end
  end

  task automatic cycle4(input logic v, input logic m, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] rdy, input logic exp_rdy, input string nm);
    @(posedge clk);
    #1;
    v4 = v; mode4 = m; sel4 = s; data4 = d; or4 = rdy;
    @(negedge clk);
    if (v) chk(nm, 32'(rdy4), 32'(exp_rdy));
    if (v && rdy4) begin
      if (m) begin
        for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
      end else begin
        exp_q[s].push_back(d);
      end
    end
  endtask

  task automatic cycle3(input logic v, input logic [1:0] s, input logic [7:0] d);
    @(posedge clk);
    #1;
    v3 = v; sel3 = s; data3 = d;
    @(negedge clk);
  endtask

  initial begin
    // Reset with arbitrary inputs applied
    rst_n = 1'b0;
    v4 = 1'b1; mode4 = 1'($urandom); sel4 = 2'($urandom); data4 = 8'($urandom); or4 = 4'($urandom);
    v3 = 1'b1; sel3 = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ov4), 32'h0);
    chk("rst_out_data", od4, 32'h0);
    chk("rst_err_sel", 32'(err4), 32'h0);
    chk("rst_drop_cnt", 32'(cnt4), 32'h0);
    chk("rst_cnt3", 32'(cnt3a), 32'h0);
    v4 = 1'b0; v3 = 1'b0; mode4 = 1'b0; or4 = 4'hF;
    rst_n = 1'b1;

    // Unicast sweep at full rate
    cycle4(1, 0, 2'd0, 8'h11, 4'hF, 1, "uc_rdy0");
    cycle4(1, 0, 2'd1, 8'h22, 4'hF, 1, "uc_rdy1");
    chk("uc_valid_a", 32'(ov4), 32'h1);
    cycle4(1, 0, 2'd2, 8'h33, 4'hF, 1, "uc_rdy2");
    chk("uc_valid_b", 32'(ov4), 32'h2);
    cycle4(1, 0, 2'd3, 8'h44, 4'hF, 1, "uc_rdy3");
    chk("uc_valid_c", 32'(ov4), 32'h4);
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("uc_valid_d", 32'(ov4), 32'h8);
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("uc_valid_e", 32'(ov4), 32'h0);

    // Back-pressure on channel 2 does not block channel 1
    cycle4(1, 0, 2'd2, 8'hA5, 4'b1011, 1, "bp_first");
    cycle4(1, 0, 2'd2, 8'h5A, 4'b1011, 0, "bp_stalled");
    chk("bp_valid_held", 32'(ov4), 32'h4);
    chk("bp_data_held", 32'(od4[23:16]), 32'hA5);
    cycle4(1, 0, 2'd1, 8'h77, 4'b1011, 1, "bp_other_ch");
    cycle4(1, 0, 2'd2, 8'h5A, 4'b1111, 1, "bp_pop_refill");
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("bp_refilled", 32'(ov4), 32'h4);
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("bp_drained", 32'(ov4), 32'h0);

    // Broadcast waits for every slot to be free
    cycle4(1, 0, 2'd3, 8'h99, 4'b0111, 1, "bc_fill3");
    cycle4(1, 1, 2'd0, 8'hC3, 4'b0111, 0, "bc_blocked");
    cycle4(1, 1, 2'd0, 8'hC3, 4'b1111, 1, "bc_release");
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("bc_all_valid", 32'(ov4), 32'hF);
    chk("bc_all_data", od4, 32'hC3C3C3C3);
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("bc_drained", 32'(ov4), 32'h0);
    chk("uc_err_quiet", 32'(err4), 32'h0);
    chk("uc_cnt_quiet", 32'(cnt4), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("ch%0d_left", i), 32'(exp_q[i].size()), 32'h0);

    // Invalid selects on three-channel instances, one with a 2-bit counter
    for (int k = 0; k < 6; k++) begin
      cycle3(1, 2'd3, 8'(k));
      chk($sformatf("bad_rdy_%0d", k), 32'({rdy3a, rdy3b}), 32'h3);
      chk($sformatf("bad_cnt_a_%0d", k), 32'(cnt3a), 32'(k));
      chk($sformatf("bad_cnt_b_%0d", k), 32'(cnt3b), (k > 3) ? 32'h3 : 32'(k));
      chk($sformatf("bad_err_%0d", k), 32'({err3a, err3b}), (k > 0) ? 32'h3 : 32'h0);
      chk($sformatf("bad_valid_%0d", k), 32'({ov3a, ov3b}), 32'h0);
    end
    cycle3(0, 2'd0, 8'h00);
    chk("bad_err_last", 32'({err3a, err3b}), 32'h3);
    chk("bad_cnt_a_end", 32'(cnt3a), 32'h6);
    chk("bad_cnt_b_sat", 32'(cnt3b), 32'h3);
    cycle3(1, 2'd1, 8'h42);
    chk("good3_err_clear", 32'({err3a, err3b}), 32'h0);
    cycle3(0, 2'd0, 8'h00);
    chk("good3_valid", 32'(ov3a), 32'h2);
    chk("good3_data", 32'(od3a), 32'h004200);
    chk("good3_cnt_hold", 32'(cnt3a), 32'h6);

    // Asynchronous reset while all slots hold a beat
    cycle4(1, 1, 2'd0, 8'h5E, 4'h0, 1, "ar_fill");
    @(posedge clk);
    #2;
    chk("ar_full_before", 32'(ov4), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", 32'(ov4), 32'h0);
    chk("ar_data_now", od4, 32'h0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    v4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle4(0, 0, 2'd0, 8'h00, 4'hF, 0, "idle");
    chk("ar_after_valid", 32'(ov4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
